seq_count_var_updn: RTL and testbench

- Parametrised loadable up/down binary counter with enable, terminal-count flag and selectable saturate/wrap mode.
- Generalises the 3-bit load-and-count-down counter to any width, adds count direction, count enable and a wrap-event strobe.
- Used as a reusable timer/iteration counter inside sequential control blocks.

---
 rtl/seq_count_var_updn.sv | 59 +++++
 tb/tb_seq_count_var_updn.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_count_var_updn.sv
// rtl/seq_count_var_updn.sv - loadable up/down counter with enable, terminal-count flag and saturate/wrap mode
module seq_count_var_updn #(
  parameter int NBITS    = 3,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [NBITS-1:0] in_,
  input  logic             en,
  input  logic             dir,
  output logic [NBITS-1:0] out,
  output logic             done,
  output logic             wrap
);

  localparam logic [NBITS-1:0] MAX_VAL = '1;

  logic [NBITS-1:0] r_out;
  logic             r_wrap;
  logic [NBITS-1:0] w_term;
  logic             w_at_term;
  logic [NBITS-1:0] w_next_out;
  logic             w_next_wrap;

  assign w_term    = dir ? MAX_VAL : '0;
  assign w_at_term = (r_out == w_term);

  // Load beats enable; at the terminal value either hold or roll to the opposite end.
  always_comb begin
    w_next_out  = r_out;
    w_next_wrap = 1'b0;
    if (ld) begin
      w_next_out = in_;
    end else if (en) begin
      if (!w_at_term) begin
        w_next_out = dir ? (r_out + 1'b1) : (r_out - 1'b1);
      end else if (!SATURATE) begin
        w_next_out  = dir ? '0 : MAX_VAL;
        w_next_wrap = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_next_out;
      r_wrap <= w_next_wrap;
    end
  end

  assign out  = r_out;
  assign wrap = r_wrap;
  assign done = w_at_term;

endmodule

// File: tb/tb_seq_count_var_updn.sv
// tb/tb_seq_count_var_updn.sv - self-checking bench for seq_count_var_updn across widths and modes
module tb_seq_count_var_updn;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld;
  logic [7:0] in_v;
  logic       en;
  logic       dir;

  logic [2:0] o3s, o3w;
  logic [3:0] o4w;
  logic [7:0] o8s, o8w;
  logic       d3s, d3w, d4w, d8s, d8w;
  logic       w3s, w3w, w4w, w8s, w8w;

  int nchk  = 0;
  int nfail = 0;

  // instance table: 0=(3,sat) 1=(3,wrap) 2=(4,wrap) 3=(8,sat) 4=(8,wrap)
  int nb [5] = '{3, 3, 4, 8, 8};
  bit sat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  int m_out [5];
  int m_wrap[5];

  logic [31:0] a_out [5];
  logic        a_done[5];
  logic        a_wrap[5];

  always #5 clk = ~clk;

  seq_count_var_updn #(.NBITS(3), .SATURATE(1'b1)) u3s (.clk(clk), .reset(reset), .ld(ld), .in_(in_v[2:0]), .en(en), .dir(dir), .out(o3s), .done(d3s), .wrap(w3s));
  seq_count_var_updn #(.NBITS(3), .SATURATE(1'b0)) u3w (.clk(clk), .reset(reset), .ld(ld), .in_(in_v[2:0]), .en(en), .dir(dir), .out(o3w), .done(d3w), .wrap(w3w));
  seq_count_var_updn #(.NBITS(4), .SATURATE(1'b0)) u4w (.clk(clk), .reset(reset), .ld(ld), .in_(in_v[3:0]), .en(en), .dir(dir), .out(o4w), .done(d4w), .wrap(w4w));
  seq_count_var_updn #(.NBITS(8), .SATURATE(1'b1)) u8s (.clk(clk), .reset(reset), .ld(ld), .in_(in_v),      .en(en), .dir(dir), .out(o8s), .done(d8s), .wrap(w8s));
  seq_count_var_updn #(.NBITS(8), .SATURATE(1'b0)) u8w (.clk(clk), .reset(reset), .ld(ld), .in_(in_v),      .en(en), .dir(dir), .out(o8w), .done(d8w), .wrap(w8w));

  assign a_out[0] = {29'd0, o3s};
  assign a_out[1] = {29'd0, o3w};
  assign a_out[2] = {28'd0, o4w};
  assign a_out[3] = {24'd0, o8s};
  assign a_out[4] = {24'd0, o8w};
  assign a_done   = '{d3s, d3w, d4w, d8s, d8w};
  assign a_wrap   = '{w3s, w3w, w4w, w8s, w8w};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int top_of(int k);
    return (1 << nb[k]) - 1;
  endfunction

  function automatic int term_of(int k, logic d);
    return d ? top_of(k) : 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 5; k++) begin
      m_out[k]  = 0;
      m_wrap[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 5; k++) begin
      m_wrap[k] = 0;
      if (ld) begin
        m_out[k] = int'(in_v) % (1 << nb[k]);
      end else if (en) begin
        if (m_out[k] != term_of(k, dir)) begin
          m_out[k] = dir ? m_out[k] + 1 : m_out[k] - 1;
        end else if (!sat[k]) begin
          m_out[k]  = dir ? 0 : top_of(k);
          m_wrap[k] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("model_out[%0d]", k), a_out[k], m_out[k]);
      chk($sformatf("model_wrap[%0d]", k), {31'd0, a_wrap[k]}, m_wrap[k]);
      chk($sformatf("model_done[%0d]", k), {31'd0, a_done[k]}, (m_out[k] == term_of(k, dir)) ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset_pulse();
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_all();
    reset = 1'b1;
  endtask

  int exp_legacy[8] = '{5, 4, 3, 2, 1, 0, 0, 0};

  initial begin
    reset = 1'b0; ld = 1'b0; en = 1'b0; dir = 1'b0; in_v = 8'd0;
    model_clear();
    #1;
    check_all();
    repeat (2) tick();
    reset = 1'b1;

    // async reset mid-cycle with comb done following dir
    ld = 1'b1; in_v = 8'd3; tick();
    ld = 1'b0;
    #2 reset = 1'b0; model_clear();
    #1;
    chk("rst_out", a_out[0], 0);
    chk("rst_wrap", {31'd0, w3s}, 0);
    chk("rst_done_dn", {31'd0, d3s}, 1);
    dir = 1'b1;
    #1;
    chk("rst_done_up", {31'd0, d3s}, 0);
    check_all();
    reset = 1'b1; dir = 1'b0;

    // legacy down count
    en = 1'b1; ld = 1'b1; in_v = 8'd5; tick();
    ld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      chk("legacy_out", a_out[0], exp_legacy[i]);
      chk("legacy_done", {31'd0, d3s}, exp_legacy[i] == 0 ? 1 : 0);
      chk("legacy_wrap", {31'd0, w3s}, 0);
    end

    // up wrap on 3-bit wrapping instance
    dir = 1'b1; ld = 1'b1; in_v = 8'd6; tick();
    ld = 1'b0;
    chk("upw_6", a_out[1], 6);
    tick(); chk("upw_7", a_out[1], 7); chk("upw_done7", {31'd0, d3w}, 1); chk("upw_wrap7", {31'd0, w3w}, 0);
    tick(); chk("upw_0", a_out[1], 0); chk("upw_wrap0", {31'd0, w3w}, 1);
    tick(); chk("upw_1", a_out[1], 1); chk("upw_wrap1", {31'd0, w3w}, 0);

    // back-to-back wrap: up wrap 7->0 then immediately down wrap 0->7
    ld = 1'b1; in_v = 8'd7; tick();
    ld = 1'b0; tick();
    chk("b2b_first", {31'd0, w3w}, 1);
    dir = 1'b0; tick();
    chk("b2b_second", {31'd0, w3w}, 1);
    chk("b2b_out", a_out[1], 7);

    // enable and load priority
    ld = 1'b1; in_v = 8'd4; tick();
    ld = 1'b0; en = 1'b0;
    repeat (3) begin tick(); chk("en_hold", a_out[0], 4); end
    ld = 1'b1; en = 1'b1; in_v = 8'd2; tick();
    chk("ld_prio", a_out[0], 2);
    ld = 1'b0; dir = 1'b1;
    tick(); chk("dir_up3", a_out[0], 3);
    tick(); chk("dir_up4", a_out[0], 4);

    // 4-bit down wrap and async reset mid-count
    dir = 1'b0; ld = 1'b1; in_v = 8'd1; tick();
    ld = 1'b0; chk("dw_1", a_out[2], 1);
    tick(); chk("dw_0", a_out[2], 0);
    tick(); chk("dw_15", a_out[2], 15); chk("dw_wrap15", {31'd0, w4w}, 1);
    tick(); tick(); tick(); chk("dw_12", a_out[2], 12);
    #2 reset = 1'b0; model_clear();
    #1 chk("dw_rst", a_out[2], 0);
    reset = 1'b1;
    #1 chk("dw_rel0", a_out[2], 0);
    tick(); chk("dw_rel15", a_out[2], 15); chk("dw_relwrap", {31'd0, w4w}, 1);

    // random phase, all instances against the model every cycle
    for (int i = 0; i < 400; i++) begin
      ld   = ($urandom_range(0, 7) == 0);
      in_v = 8'($urandom);
      en   = ($urandom_range(0, 3) != 0);
      dir  = 1'($urandom);
      if ($urandom_range(0, 3) == 0) in_v = dir ? 8'hff : 8'h00;
      #1;
      check_all();
      if ($urandom_range(0, 60) == 0) async_reset_pulse();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
